// File: rtl/arya_mem_loader_pkg.sv
// Shared definitions for the arya memory loader: host opcodes, controller
// states and default memory geometry.
package arya_mem_loader_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 64;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'b00,
      OP_VERIFY = 2'b01,
      OP_RUN    = 2'b10,
      OP_HALT   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_VERIFY = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RUN    = 3'd4
   } state_e;

endpackage

// File: rtl/arya_mem_loader_verify.sv
// Delay line that aligns each issued VERIFY read ({valid, addr, expected})
// with the memory's registered read data.
module arya_verify_delay
   import arya_mem_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              pending
);

   logic [DEPTH-1:0]  valid_r;
   logic [ADDR_W-1:0] addr_r [DEPTH];
   logic [DATA_W-1:0] data_r [DEPTH];

   // Shift register: stage 0 takes the new issue, the last stage feeds the compare.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_r[i] <= '0;
            data_r[i] <= '0;
         end
      end else begin
         valid_r[0] <= in_valid;
         addr_r[0]  <= in_addr;
         data_r[0]  <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            valid_r[i] <= valid_r[i-1];
            addr_r[i]  <= addr_r[i-1];
            data_r[i]  <= data_r[i-1];
         end
      end
   end

   // Pending means reads still in flight beyond the one being compared now.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         pending = pending | valid_r[i];
      end
   end

   assign out_valid = valid_r[DEPTH-1];
   assign out_addr  = addr_r[DEPTH-1];
   assign out_data  = data_r[DEPTH-1];

endmodule

// File: rtl/arya_mem_loader.sv
// Host-side initiator for the arya core memory debug port: burst load,
// read-back verify, and run/halt control of the core.
module arya_mem_loader
   import arya_mem_loader_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              core_en,
   output logic              core_setup_mem,
   output logic              core_verify_mem,
   output logic [ADDR_W-1:0] core_mem_addr,
   output logic [DATA_W-1:0] core_mem_data,
   input  logic [DATA_W-1:0] core_mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              mismatch,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   ERR_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_e            state_r, state_s;
   op_e               op_s;
   logic [ADDR_W-1:0] addr_r, hold_addr_r, first_err_addr_r, dl_addr_s;
   logic [ADDR_W:0]   remain_r, err_count_r;
   logic [DATA_W-1:0] dl_data_s;
   logic              done_r, mismatch_r, dl_valid_s, dl_pending_s;
   logic              cmd_fire_s, beat_s, last_beat_s, idle_fire_s, cmp_fail_s;

   assign op_s        = op_e'(cmd_op);
   assign cmd_ready   = (state_r == ST_IDLE) | ((state_r == ST_RUN) & (op_s == OP_HALT));
   assign wr_ready    = (state_r == ST_LOAD) | (state_r == ST_VERIFY);
   assign cmd_fire_s  = cmd_valid & cmd_ready;
   assign idle_fire_s = cmd_fire_s & (state_r == ST_IDLE);
   assign beat_s      = wr_valid & wr_ready;
   assign last_beat_s = beat_s & (remain_r == LEN_ONE);
   assign cmp_fail_s  = dl_valid_s & (core_mem_rdata != dl_data_s);

   assign core_en         = (state_r == ST_RUN);
   assign core_setup_mem  = (state_r == ST_LOAD) & wr_valid;
   assign core_verify_mem = (state_r == ST_VERIFY) | (state_r == ST_DRAIN);
   assign core_mem_addr   = beat_s ? addr_r : hold_addr_r;
   assign core_mem_data   = core_setup_mem ? wr_data : '0;
   assign busy            = (state_r != ST_IDLE) & (state_r != ST_RUN);
   assign done            = done_r;
   assign mismatch        = mismatch_r;
   assign err_count       = err_count_r;
   assign first_err_addr  = first_err_addr_r;

   arya_verify_delay #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (READ_LATENCY)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (beat_s & (state_r == ST_VERIFY)),
      .in_addr   (addr_r),
      .in_data   (wr_data),
      .out_valid (dl_valid_s),
      .out_addr  (dl_addr_s),
      .out_data  (dl_data_s),
      .pending   (dl_pending_s)
   );

   // Controller state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Next-state logic; zero-length LOAD/VERIFY stays in IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_fire_s) begin
               case (op_s)
                  OP_LOAD:   state_s = (cmd_len != '0) ? ST_LOAD : ST_IDLE;
                  OP_VERIFY: state_s = (cmd_len != '0) ? ST_VERIFY : ST_IDLE;
                  OP_RUN:    state_s = ST_RUN;
                  default:   state_s = ST_IDLE;
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD:   state_s = last_beat_s ? ST_IDLE : ST_LOAD;
         ST_VERIFY: state_s = last_beat_s ? ST_DRAIN : ST_VERIFY;
         ST_DRAIN:  state_s = dl_pending_s ? ST_DRAIN : ST_IDLE;
         ST_RUN:    state_s = cmd_fire_s ? ST_IDLE : ST_RUN;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Address/count tracking, completion pulse and verify status.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_r           <= '0;
         hold_addr_r      <= '0;
         remain_r         <= '0;
         done_r           <= 1'b0;
         mismatch_r       <= 1'b0;
         err_count_r      <= '0;
         first_err_addr_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (idle_fire_s) begin
            addr_r   <= cmd_addr;
            remain_r <= cmd_len;
            if (((op_s == OP_LOAD) || (op_s == OP_VERIFY)) && (cmd_len == '0))
               done_r <= 1'b1;
            if (op_s == OP_VERIFY) begin
               mismatch_r       <= 1'b0;
               err_count_r      <= '0;
               first_err_addr_r <= '0;
            end
         end else if (beat_s) begin
            addr_r      <= addr_r + ADDR_ONE;
            remain_r    <= remain_r - LEN_ONE;
            hold_addr_r <= addr_r;
            if (last_beat_s && (state_r == ST_LOAD))
               done_r <= 1'b1;
         end else if ((state_r == ST_DRAIN) && !dl_pending_s) begin
            done_r <= 1'b1;
         end
         // The delay line is empty in IDLE, so this never races the VERIFY clear.
         if (cmp_fail_s) begin
            mismatch_r <= 1'b1;
            if (err_count_r != ERR_MAX)
               err_count_r <= err_count_r + LEN_ONE;
            if (err_count_r == '0)
               first_err_addr_r <= dl_addr_s;
         end
      end
   end

endmodule

// File: doc/arya_mem_loader.md
Name: arya_mem_loader

Overview:
- Host-side initiator for the core's memory debug port (setup_mem / verify_mem / mem_addr_in / mem_data_in / mem_data_out) and its run enable.
- Accepts commands and a 64-bit data stream from the host, then does one of: burst-load program/data words into the unified 1024-word memory; read back and compare against an expected stream; start or stop the core.
- Sits between the host interface logic and one arya core instance.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 64, memory word width.
- READ_LATENCY, 1, cycles from core_mem_addr to a valid core_mem_rdata (port A of the memory is registered).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 LOAD, 01 VERIFY, 10 RUN, 11 HALT.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  ADDR_W+1  word count, 0..1024.
- wr_valid  in  1  data/expected word offered.
- wr_ready  out  1  data word accepted on wr_valid & wr_ready.
- wr_data  in  DATA_W  load word, or expected word during VERIFY.
- core_en  out  1  to arya en.
- core_setup_mem  out  1  to arya setup_mem.
- core_verify_mem  out  1  to arya verify_mem.
- core_mem_addr  out  ADDR_W  to arya mem_addr_in.
- core_mem_data  out  DATA_W  to arya mem_data_in.
- core_mem_rdata  in  DATA_W  from arya mem_data_out.
- busy  out  1  high in any state other than IDLE and RUN.
- done  out  1  one-cycle pulse when LOAD or VERIFY completes.
- mismatch  out  1  sticky; set on any VERIFY compare failure, cleared when a new VERIFY is accepted.
- err_count  out  ADDR_W+1  number of failed compares in the last VERIFY.
- first_err_addr  out  ADDR_W  address of the first failed compare.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0 except cmd_ready=1.
- States: IDLE, LOAD, VERIFY, DRAIN, RUN.
- IDLE:
  - cmd_ready=1.
  - LOAD with len>0 -> LOAD. VERIFY with len>0 -> VERIFY.
  - RUN -> RUN. HALT -> no-op.
  - len==0 LOAD/VERIFY: done pulses next cycle, state stays IDLE.
- LOAD:
  - wr_ready=1.
  - Each accepted beat drives core_setup_mem=1, core_mem_addr=current addr, core_mem_data=wr_data in that same cycle (combinational from the handshake; the registered address counter supplies addr).
  - addr increments modulo 2^ADDR_W (1023 wraps to 0). Remaining count decrements.
  - On the last beat: -> IDLE, done pulses the following cycle.
  - wr_valid low: no write, setup_mem=0.
- VERIFY:
  - core_verify_mem=1 for the whole state and through DRAIN.
  - wr_ready=1 while words remain.
  - Each accepted beat issues core_mem_addr=addr and pushes {valid, addr, wr_data} into a READ_LATENCY-deep delay line.
  - At the delay-line output, compare core_mem_rdata with the expected word.
  - On mismatch: err_count++ (saturating at 1024), mismatch=1, first_err_addr captured if err_count was 0.
  - core_mem_addr holds its last value when no beat is accepted.
  - After the last issue -> DRAIN.
- DRAIN:
  - wr_ready=0. Waits until the delay line is empty (READ_LATENCY cycles), finishing the compares.
  - Then -> IDLE, done pulses.
  - Accepting a new VERIFY zeroes err_count, first_err_addr and mismatch.
- RUN:
  - core_en=1.
  - cmd_ready=1 only when cmd_op==HALT. HALT -> IDLE with core_en=0 from the next cycle.
  - Other ops stall (not accepted) until HALT.
- Exclusivity:
  - core_setup_mem and core_verify_mem are never high together.
  - core_en is never high together with either of them.
  - cmd_ready=0 in LOAD, VERIFY and DRAIN.
- Reset mid-LOAD/VERIFY: abort immediately. Partially written memory is left as is; status outputs clear.

Decomposition:
- Shared package: op encodings (OP_LOAD, OP_VERIFY, OP_RUN, OP_HALT), state enum, ADDR_W/DATA_W defaults.
- One sub-module: arya_verify_delay, a READ_LATENCY-deep shift register of {valid, addr, expected}.

Test Plan:
- LOAD addr=0 len=4 with data 0x11..0x44, wr_valid always high -> setup_mem high 4 cycles at addrs 0,1,2,3 with matching data; done pulses once; busy falls.
- VERIFY addr=0 len=4, expected matches the loaded data -> verify_mem high 4+READ_LATENCY cycles; done pulses; mismatch=0; err_count=0.
- VERIFY with word 2 expected 0xDEAD (memory holds 0x33) -> mismatch=1, err_count=1, first_err_addr=2.
- LOAD addr=1022 len=4 with wr_valid toggled every other cycle -> writes only on valid beats, at addrs 1022,1023,0,1; no write on idle cycles.
- RUN, then offer LOAD -> cmd_ready=0 and core_en=1 held; then HALT -> accepted, core_en=0 next cycle, the pending LOAD is accepted in IDLE.
- Assert reset mid-LOAD after 2 of 5 beats -> all outputs 0 asynchronously, cmd_ready=1 after release, no further setup_mem pulses.
